i2s_rx_deframer: RTL and testbench

Serial audio front end for the voice-change path. Samples an I2S (or left-justified) bit stream on the bit clock, recovers left/right slot boundaries from the word-select line and delivers each channel word as a parallel `data` bus with one-cycle `l_vld` / `r_vld` strobes. It feeds the pre-emphasis stage directly, which consumes `data`, `l_vld` and `r_vld` in the same `sck` domain.

---
 rtl/i2s_rx_deframer.sv | 127 ++++++++++++
 tb/tb_i2s_rx_deframer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deframer.sv
// Receive-side I2S deframer: recovers left/right words from lrck/sdin on sck.
// Define I2S_RX_LEFT_JUSTIFIED_EN for left-justified framing (default: standard I2S).
`timescale 1ns/1ps
module i2s_rx_deframer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  sck,
    input  logic                  voide_rst,
    input  logic                  lrck,
    input  logic                  sdin,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  l_vld,
    output logic                  r_vld,
    output logic                  short_err,
    output logic                  locked
);
    localparam int CW = $clog2(DATA_WIDTH);
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam bit LJ = 1'b1;
`else
    localparam bit LJ = 1'b0;
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

    // In I2S the E edge itself is the one-sck MSB delay (its bit belongs to the old
    // slot), so slots always start straight into SHIFT.
    typedef enum logic [1:0] {ST_SYNC, ST_SHIFT, ST_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  lrck_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-2:0] shift_q, shift_d;
    logic                  chan_q, chan_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  l_vld_q, l_vld_d;
    logic                  r_vld_q, r_vld_d;
    logic                  short_err_q, short_err_d;
    logic                  locked_q, locked_d;

    logic                  ev;
    logic                  last_bit;
    logic                  lsb_bit;
    logic [DATA_WIDTH-1:0] shift_cat;
    logic [DATA_WIDTH-2:0] shift_in;
    logic [DATA_WIDTH-1:0] word_cat;
    logic [DATA_WIDTH-1:0] aligned;

    assign ev        = lrck ^ lrck_q;
    assign last_bit  = (cnt_q == LAST_IDX);
    assign shift_cat = {shift_q, sdin};
    assign shift_in  = shift_cat[DATA_WIDTH-2:0];
    // An LJ E edge already carries the next slot's MSB, so it adds no bit here.
    assign lsb_bit   = (LJ && ev) ? 1'b0 : sdin;
    assign word_cat  = {shift_q, lsb_bit};
    assign aligned   = word_cat << (LAST_IDX - cnt_q);

    always_ff @(posedge sck or posedge voide_rst) begin
        if (voide_rst) begin
            state_q     <= ST_SYNC;
            lrck_q      <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            chan_q      <= 1'b0;
            data_q      <= '0;
            l_vld_q     <= 1'b0;
            r_vld_q     <= 1'b0;
            short_err_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lrck_q      <= lrck;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            chan_q      <= chan_d;
            data_q      <= data_d;
            l_vld_q     <= l_vld_d;
            r_vld_q     <= r_vld_d;
            short_err_q <= short_err_d;
            locked_q    <= locked_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        chan_d  = chan_q;
        if (ev) begin
            chan_d  = lrck;
            state_d = ST_SHIFT;
            if (LJ) begin
                cnt_d   = CW'(1);
                shift_d = shift_in;
            end else begin
                cnt_d   = '0;
            end
        end else if (state_q == ST_SHIFT) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
                state_d = ST_WAIT;
            end
        end
    end

    always_comb begin
        data_d      = data_q;
        l_vld_d     = 1'b0;
        r_vld_d     = 1'b0;
        short_err_d = 1'b0;
        locked_d    = locked_q | ev;
        // A word ends on its LSB or on an early E (short slot, zero-filled).
        if ((state_q == ST_SHIFT) && (ev || last_bit)) begin
            data_d      = aligned;
            l_vld_d     = ~chan_q;
            r_vld_d     = chan_q;
            short_err_d = ev && (LJ || !last_bit);
        end
    end

    assign data      = data_q;
    assign l_vld     = l_vld_q;
    assign r_vld     = r_vld_q;
    assign short_err = short_err_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_i2s_rx_deframer.sv
// Directed testbench for i2s_rx_deframer; follows I2S_RX_LEFT_JUSTIFIED_EN like the DUT.
`timescale 1ns/1ps
module tb_i2s_rx_deframer;
    localparam int DW = 8;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam int OFF = 0;
`else
    localparam int OFF = 1;
`endif

    logic          sck       = 1'b0;
    logic          voide_rst = 1'b1;
    logic          lrck      = 1'b0;
    logic          sdin      = 1'b0;
    logic [DW-1:0] data;
    logic          l_vld;
    logic          r_vld;
    logic          short_err;
    logic          locked;

    typedef struct {
        int            e;
        logic          l;
        logic          r;
        logic          se;
        logic [DW-1:0] d;
    } ev_t;

    ev_t           evq[$];
    logic          lr_a   [0:511];
    logic          sd_a   [0:511];
    logic          lk_log [0:511];
    logic [DW-1:0] d_log  [0:511];
    int            pos;
    int            both_cnt;
    int            n_vec = 0;
    int            n_err = 0;

    i2s_rx_deframer #(.DATA_WIDTH(DW)) dut (
        .sck       (sck),
        .voide_rst (voide_rst),
        .lrck      (lrck),
        .sdin      (sdin),
        .data      (data),
        .l_vld     (l_vld),
        .r_vld     (r_vld),
        .short_err (short_err),
        .locked    (locked)
    );

    always #5 sck = ~sck;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_stream();
        for (int i = 0; i < 512; i++) begin
            lr_a[i]   = 1'b0;
            sd_a[i]   = 1'b0;
            lk_log[i] = 1'b0;
            d_log[i]  = '0;
        end
        pos      = 0;
        both_cnt = 0;
        evq.delete();
    endtask

    task automatic do_reset();
        voide_rst = 1'b1;
        lrck      = 1'b0;
        sdin      = 1'b0;
        repeat (2) @(posedge sck);
        @(negedge sck);
        voide_rst = 1'b0;
        clear_stream();
    endtask

    // Appends one slot; word bits go MSB first, starting OFF edges after the slot start.
    task automatic add_slot(input logic lr, input int len, input int nbits, input logic [31:0] word);
        for (int i = 0; i < len; i++) begin
            lr_a[pos + i]       = lr;
            sd_a[pos + OFF + i] = (i < nbits) ? word[nbits - 1 - i] : (i % 2 == 1);
        end
        pos += len;
    endtask

    task automatic tick(input int j);
        @(negedge sck);
        lrck = lr_a[j];
        sdin = sd_a[j];
        @(posedge sck);
        #1;
        lk_log[j] = locked;
        d_log[j]  = data;
        if (l_vld && r_vld) both_cnt++;
        if (l_vld || r_vld || short_err)
            evq.push_back('{j, l_vld, r_vld, short_err, data});
    endtask

    task automatic play(input int from, input int to);
        for (int j = from; j <= to; j++) tick(j);
    endtask

    task automatic test_reset();
        voide_rst = 1'b1;
        repeat (2) @(posedge sck);
        #1;
        n_vec++; if (data !== 8'h00)    begin n_err++; $display("FAIL rst_data: got %h want 00", data); end
        n_vec++; if (l_vld !== 1'b0)    begin n_err++; $display("FAIL rst_l_vld: got %b want 0", l_vld); end
        n_vec++; if (r_vld !== 1'b0)    begin n_err++; $display("FAIL rst_r_vld: got %b want 0", r_vld); end
        n_vec++; if (short_err !== 1'b0) begin n_err++; $display("FAIL rst_short_err: got %b want 0", short_err); end
        n_vec++; if (locked !== 1'b0)   begin n_err++; $display("FAIL rst_locked: got %b want 0", locked); end
        @(negedge sck);
        voide_rst = 1'b0;
        clear_stream();
        add_slot(1'b1, 16, 8, 32'h11);
        add_slot(1'b0, 16, 8, 32'h22);
        add_slot(1'b1, 16, 8, 32'h33);
        play(0, 19);
        n_vec++; if (d_log[19] !== 8'h11) begin n_err++; $display("FAIL pre_rst_data: got %h want 11", d_log[19]); end
        n_vec++; if (lk_log[19] !== 1'b1) begin n_err++; $display("FAIL pre_rst_locked: got %b want 1", lk_log[19]); end
        @(negedge sck);
        voide_rst = 1'b1;
        #1;
        n_vec++;
        if ({data, l_vld, r_vld, short_err, locked} !== '0) begin
            n_err++;
            $display("FAIL midslot_rst_outputs: got data %h l %b r %b se %b lock %b want all 0",
                     data, l_vld, r_vld, short_err, locked);
        end
        @(posedge sck);
        @(negedge sck);
        voide_rst = 1'b0;
        evq.delete();
        play(20, 47);
        n_vec++; if (lk_log[31] !== 1'b0) begin n_err++; $display("FAIL post_rst_locked_early: got %b want 0", lk_log[31]); end
        n_vec++; if (lk_log[32] !== 1'b1) begin n_err++; $display("FAIL post_rst_locked_on_e: got %b want 1", lk_log[32]); end
        n_vec++;
        if (evq.size() != 1) begin
            n_err++; $display("FAIL post_rst_count: got %0d strobes want 1", evq.size());
        end else begin
            n_vec++;
            if (evq[0].e != 32 + DW - 1 + OFF || {evq[0].l, evq[0].r, evq[0].se} !== 3'b010 || evq[0].d !== 8'h33) begin
                n_err++;
                $display("FAIL post_rst_word: got edge %0d lrs %b%b%b data %h want edge %0d lrs 010 data 33",
                         evq[0].e, evq[0].l, evq[0].r, evq[0].se, evq[0].d, 32 + DW - 1 + OFF);
            end
        end
    endtask

`ifndef I2S_RX_LEFT_JUSTIFIED_EN
    task automatic test_i2s_16();
        ev_t ex [3];
        do_reset();
        add_slot(1'b1, 16, 8, 32'h11);
        add_slot(1'b0, 16, 8, 32'hA5);
        add_slot(1'b1, 16, 8, 32'h3C);
        play(0, pos - 1);
        ex[0] = '{8,  1'b0, 1'b1, 1'b0, 8'h11};
        ex[1] = '{24, 1'b1, 1'b0, 1'b0, 8'hA5};
        ex[2] = '{40, 1'b0, 1'b1, 1'b0, 8'h3C};
        n_vec++;
        if (evq.size() != 3) begin n_err++; $display("FAIL i2s16_count: got %0d strobes want 3", evq.size()); end
        for (int i = 0; i < 3 && i < evq.size(); i++) begin
            n_vec++;
            if (evq[i].e != ex[i].e || {evq[i].l, evq[i].r, evq[i].se} !== {ex[i].l, ex[i].r, ex[i].se} || evq[i].d !== ex[i].d) begin
                n_err++;
                $display("FAIL i2s16_word%0d: got edge %0d lrs %b%b%b data %h want edge %0d lrs %b%b%b data %h",
                         i, evq[i].e, evq[i].l, evq[i].r, evq[i].se, evq[i].d, ex[i].e, ex[i].l, ex[i].r, ex[i].se, ex[i].d);
            end
        end
        n_vec++; if (d_log[39] !== 8'hA5) begin n_err++; $display("FAIL i2s16_hold: got %h want a5", d_log[39]); end
    endtask

    task automatic test_back_to_back();
        ev_t ex [4];
        do_reset();
        add_slot(1'b1, 8, 8, 32'h81);
        add_slot(1'b0, 8, 8, 32'h7E);
        add_slot(1'b1, 8, 8, 32'h81);
        add_slot(1'b0, 8, 8, 32'h7E);
        add_slot(1'b1, 8, 8, 32'h00);
        play(0, pos - 1);
        ex[0] = '{8,  1'b0, 1'b1, 1'b0, 8'h81};
        ex[1] = '{16, 1'b1, 1'b0, 1'b0, 8'h7E};
        ex[2] = '{24, 1'b0, 1'b1, 1'b0, 8'h81};
        ex[3] = '{32, 1'b1, 1'b0, 1'b0, 8'h7E};
        n_vec++;
        if (evq.size() != 4) begin n_err++; $display("FAIL b2b_count: got %0d strobes want 4", evq.size()); end
        for (int i = 0; i < 4 && i < evq.size(); i++) begin
            n_vec++;
            if (evq[i].e != ex[i].e || {evq[i].l, evq[i].r, evq[i].se} !== {ex[i].l, ex[i].r, ex[i].se} || evq[i].d !== ex[i].d) begin
                n_err++;
                $display("FAIL b2b_word%0d: got edge %0d lrs %b%b%b data %h want edge %0d lrs %b%b%b data %h",
                         i, evq[i].e, evq[i].l, evq[i].r, evq[i].se, evq[i].d, ex[i].e, ex[i].l, ex[i].r, ex[i].se, ex[i].d);
            end
        end
    endtask

    task automatic test_short_slot();
        ev_t ex [3];
        do_reset();
        add_slot(1'b1, 16, 8, 32'h3C);
        add_slot(1'b0, 5,  5, 32'b10110);
        add_slot(1'b1, 16, 8, 32'h3C);
        play(0, pos - 1);
        ex[0] = '{8,  1'b0, 1'b1, 1'b0, 8'h3C};
        ex[1] = '{21, 1'b1, 1'b0, 1'b1, 8'hB0};
        ex[2] = '{29, 1'b0, 1'b1, 1'b0, 8'h3C};
        n_vec++;
        if (evq.size() != 3) begin n_err++; $display("FAIL short_count: got %0d strobes want 3", evq.size()); end
        for (int i = 0; i < 3 && i < evq.size(); i++) begin
            n_vec++;
            if (evq[i].e != ex[i].e || {evq[i].l, evq[i].r, evq[i].se} !== {ex[i].l, ex[i].r, ex[i].se} || evq[i].d !== ex[i].d) begin
                n_err++;
                $display("FAIL short_word%0d: got edge %0d lrs %b%b%b data %h want edge %0d lrs %b%b%b data %h",
                         i, evq[i].e, evq[i].l, evq[i].r, evq[i].se, evq[i].d, ex[i].e, ex[i].l, ex[i].r, ex[i].se, ex[i].d);
            end
        end
        n_vec++; if (d_log[28] !== 8'hB0) begin n_err++; $display("FAIL short_hold: got %h want b0", d_log[28]); end
    endtask

    task automatic test_long_slot();
        ev_t ex [3];
        do_reset();
        add_slot(1'b1, 32, 8, 32'h3C);
        add_slot(1'b0, 32, 8, 32'hA5);
        add_slot(1'b1, 32, 8, 32'h5A);
        play(0, pos - 1);
        ex[0] = '{8,  1'b0, 1'b1, 1'b0, 8'h3C};
        ex[1] = '{40, 1'b1, 1'b0, 1'b0, 8'hA5};
        ex[2] = '{72, 1'b0, 1'b1, 1'b0, 8'h5A};
        n_vec++;
        if (evq.size() != 3) begin n_err++; $display("FAIL long_count: got %0d strobes want 3", evq.size()); end
        for (int i = 0; i < 3 && i < evq.size(); i++) begin
            n_vec++;
            if (evq[i].e != ex[i].e || {evq[i].l, evq[i].r, evq[i].se} !== {ex[i].l, ex[i].r, ex[i].se} || evq[i].d !== ex[i].d) begin
                n_err++;
                $display("FAIL long_word%0d: got edge %0d lrs %b%b%b data %h want edge %0d lrs %b%b%b data %h",
                         i, evq[i].e, evq[i].l, evq[i].r, evq[i].se, evq[i].d, ex[i].e, ex[i].l, ex[i].r, ex[i].se, ex[i].d);
            end
        end
        n_vec++; if (both_cnt != 0) begin n_err++; $display("FAIL long_both_strobes: got %0d cycles want 0", both_cnt); end
    endtask
`else
    task automatic test_left_justified();
        ev_t ex [5];
        do_reset();
        add_slot(1'b1, 16, 8, 32'h11);
        add_slot(1'b0, 16, 8, 32'h5A);
        add_slot(1'b1, 16, 8, 32'hC3);
        add_slot(1'b0, 5,  5, 32'b10110);
        add_slot(1'b1, 16, 8, 32'h3C);
        play(0, pos - 1);
        ex[0] = '{7,  1'b0, 1'b1, 1'b0, 8'h11};
        ex[1] = '{23, 1'b1, 1'b0, 1'b0, 8'h5A};
        ex[2] = '{39, 1'b0, 1'b1, 1'b0, 8'hC3};
        ex[3] = '{53, 1'b1, 1'b0, 1'b1, 8'hB0};
        ex[4] = '{60, 1'b0, 1'b1, 1'b0, 8'h3C};
        n_vec++;
        if (evq.size() != 5) begin n_err++; $display("FAIL lj_count: got %0d strobes want 5", evq.size()); end
        for (int i = 0; i < 5 && i < evq.size(); i++) begin
            n_vec++;
            if (evq[i].e != ex[i].e || {evq[i].l, evq[i].r, evq[i].se} !== {ex[i].l, ex[i].r, ex[i].se} || evq[i].d !== ex[i].d) begin
                n_err++;
                $display("FAIL lj_word%0d: got edge %0d lrs %b%b%b data %h want edge %0d lrs %b%b%b data %h",
                         i, evq[i].e, evq[i].l, evq[i].r, evq[i].se, evq[i].d, ex[i].e, ex[i].l, ex[i].r, ex[i].se, ex[i].d);
            end
        end
        n_vec++; if (both_cnt != 0) begin n_err++; $display("FAIL lj_both_strobes: got %0d cycles want 0", both_cnt); end
    endtask
`endif

    initial begin
        test_reset();
`ifndef I2S_RX_LEFT_JUSTIFIED_EN
        test_i2s_16();
        test_back_to_back();
        test_short_slot();
        test_long_slot();
`else
        test_left_justified();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
